capture_ram_arbiter: RTL and testbench

Shares the single-port 256K×8 capture BRAM between two masters. The logic-capture writer always has priority. A host-side burst reader streams stored samples out over a valid/ready interface. The block sits between the capture engine, the BRAM and the register/UART readout path, and owns every BRAM control pin.

---
 rtl/capture_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_capture_ram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ram_arbiter.sv
// capture_ram_arbiter: shares one single-port capture BRAM between the
// capture writer (always wins) and a credit-limited burst reader.
// Ports: clk/reset (sync, active-high); cap_* capture write strobe;
//   rd_start/rd_base/rd_count burst request, rd_busy/rd_done status;
//   m_data/m_valid/m_ready output stream; ram_* BRAM pins;
//   cap_wr_count saturating count of granted capture writes.
module capture_ram_arbiter #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_en,
   input  logic              cap_we,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W:0]   rd_count,
   output logic              rd_busy,
   output logic              rd_done,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W:0]   cap_wr_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 2;
   localparam logic [OW-1:0] DEPTH = OW'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   rd_addr, rd_addr_nx, issue_addr;
   logic [ADDR_W:0]     rd_left, rd_left_nx;
   logic                wr_grant, rd_issue, done_nx;
   logic                pop, push, out_load;
   logic                fifo_wr, fifo_rd, credit_ok;
   logic [RD_LAT-1:0]   vld_sr;
   logic [CW-1:0]       inflight, fifo_cnt;
   logic [PW-1:0]       wptr, rptr;
   logic [OW-1:0]       occ;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

   assign wr_grant = cap_en & cap_we;
   assign pop      = m_valid & m_ready;
   assign push     = vld_sr[RD_LAT-1];
   assign out_load = !m_valid || pop;
   assign fifo_rd  = out_load && (fifo_cnt != '0);
   assign fifo_wr  = push && !(out_load && (fifo_cnt == '0));

   // The word leaving this cycle frees its slot for the next issue,
   // which is what sustains one word per cycle.
   assign occ = OW'(inflight) + OW'(fifo_cnt)
              + OW'(m_valid) - OW'(pop);
   assign credit_ok = occ < DEPTH;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Read decisions are made one cycle ahead of the registered BRAM pins,
   // so a start accepted in IDLE already schedules the first read.
   always_comb begin
      state_nx   = state;
      rd_addr_nx = rd_addr;
      rd_left_nx = rd_left;
      issue_addr = rd_addr;
      rd_issue   = 1'b0;
      done_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (rd_start) begin
               if (rd_count == '0) begin
                  done_nx = 1'b1;
               end else begin
                  state_nx   = ISSUE;
                  issue_addr = rd_base;
                  rd_issue   = !wr_grant && credit_ok;
                  rd_addr_nx = rd_base + ADDR_W'(rd_issue);
                  rd_left_nx = rd_count - (ADDR_W+1)'(rd_issue);
               end
            end
         end
         ISSUE: begin
            if (rd_left == '0) begin
               state_nx = DRAIN;
            end else begin
               rd_issue = !wr_grant && credit_ok;
               if (rd_issue) begin
                  rd_addr_nx = rd_addr + ADDR_W'(1);
                  rd_left_nx = rd_left - (ADDR_W+1)'(1);
               end
            end
         end
         DRAIN: begin
            if (inflight == '0 && fifo_cnt == '0 && pop) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wptr] <= ram_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr      <= '0;
         rd_left      <= '0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         vld_sr       <= '0;
         inflight     <= '0;
         fifo_cnt     <= '0;
         wptr         <= '0;
         rptr         <= '0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         rd_busy      <= 1'b0;
         rd_done      <= 1'b0;
         cap_wr_count <= '0;
      end else begin
         rd_addr <= rd_addr_nx;
         rd_left <= rd_left_nx;
         ram_en  <= wr_grant | rd_issue;
         ram_we  <= wr_grant;
         if (wr_grant) begin
            ram_addr  <= cap_addr;
            ram_wdata <= cap_data;
         end else if (rd_issue) begin
            ram_addr <= issue_addr;
         end
         // Tag follows each read issued on the pins until its data returns.
         vld_sr[0] <= ram_en & ~ram_we;
         for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
         inflight <= inflight + CW'(rd_issue) - CW'(push);
         if (fifo_wr) wptr <= wptr + PW'(1);
         if (fifo_rd) rptr <= rptr + PW'(1);
         fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(fifo_rd);
         if (out_load) begin
            if (fifo_cnt != '0) begin
               m_data  <= fifo_mem[rptr];
               m_valid <= 1'b1;
            end else if (push) begin
               m_data  <= ram_rdata;
               m_valid <= 1'b1;
            end else begin
               m_valid <= 1'b0;
            end
         end
         rd_busy <= state_nx != IDLE;
         rd_done <= done_nx;
         if (wr_grant && cap_wr_count != WR_MAX)
            cap_wr_count <= cap_wr_count + (ADDR_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_capture_ram_arbiter.sv
// tb_capture_ram_arbiter: random and directed bursts with capture traffic,
// BRAM behavioural model and queue scoreboard for reads, writes and stream.
module tb_capture_ram_arbiter;

   localparam int AW    = 18;
   localparam int DW    = 8;
   localparam int RL    = 2;
   localparam int FD    = 4;
   localparam int MEM_N = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          cap_en, cap_we;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_data;
   logic          rd_start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_count;
   logic          rd_busy, rd_done;
   logic [DW-1:0] m_data;
   logic          m_valid, m_ready;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic [AW:0]   cap_wr_count;

   always #5 clk = ~clk;

   capture_ram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset),
      .cap_en(cap_en), .cap_we(cap_we),
      .cap_addr(cap_addr), .cap_data(cap_data),
      .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
      .rd_busy(rd_busy), .rd_done(rd_done),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .cap_wr_count(cap_wr_count)
   );

   // Power-up contents; addresses 0x10..0x14 hold 0xA0..0xA4.
   function automatic logic [7:0] f_init(input logic [AW-1:0] a);
      return a[7:0] ^ 8'hB0 ^ a[15:8] ^ {a[17:16], 6'b0};
   endfunction

   // BRAM model: written cells override the power-up contents.
   logic [7:0] bram   [MEM_N];
   bit         bvalid [MEM_N];
   logic [7:0] rpipe  [RL];
   assign ram_rdata = rpipe[RL-1];

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         bram[ram_addr]   <= ram_wdata;
         bvalid[ram_addr] <= 1'b1;
      end
      if (ram_en && !ram_we)
         rpipe[0] <= bvalid[ram_addr] ? bram[ram_addr] : f_init(ram_addr);
      else
         rpipe[0] <= 8'($urandom);
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
   end

   // Reference memory view kept by the stimulus side.
   logic [7:0] ref_wr [int];
   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : f_init(a);
   endfunction

   // Capture rule: a strobe in one cycle is a BRAM write in the next.
   logic          wr_pend = 1'b0;
   logic [AW-1:0] wr_a;
   logic [DW-1:0] wr_d;
   int            cap_strobes = 0;
   int            cyc = 0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      wr_pend <= !reset && cap_en && cap_we;
      wr_a    <= cap_addr;
      wr_d    <= cap_data;
      if (reset) cap_strobes <= 0;
      else if (cap_en && cap_we && cap_strobes < MEM_N)
         cap_strobes <= cap_strobes + 1;
   end

   int errors = 0;
   int checks = 0;
   int reads_seen = 0, hs_seen = 0, done_cnt = 0, max_out = 0;
   bit stall_prev = 1'b0;
   logic [7:0] stall_data;
   logic [AW-1:0] exp_raddr [$];
   logic [7:0]    exp_data  [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboards whenever the DUT presents something.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (ram_en && !ram_we) begin
            reads_seen++;
            chk("rd_expected", 32'(exp_raddr.size() != 0), 32'd1);
            if (exp_raddr.size() != 0)
               chk("rd_addr", 32'(ram_addr), 32'(exp_raddr.pop_front()));
         end
         if (reads_seen - hs_seen > max_out) max_out = reads_seen - hs_seen;
         if (wr_pend || ram_we) begin
            chk("wr_strobe", 32'({ram_en, ram_we}), 32'({wr_pend, wr_pend}));
            if (wr_pend) begin
               chk("wr_addr", 32'(ram_addr), 32'(wr_a));
               chk("wr_data", 32'(ram_wdata), 32'(wr_d));
            end
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(stall_data));
         end
         if (m_valid && m_ready) begin
            hs_seen++;
            chk("hs_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0)
               chk("m_data", 32'(m_data), 32'(exp_data.pop_front()));
         end
         stall_prev = m_valid && !m_ready;
         stall_data = m_data;
         if (rd_done) done_cnt++;
      end
   end

   // Per-cycle input pattern for each burst mode.
   task automatic drive_cycle(input int mode, input int k);
      cap_en = 1'b0;
      cap_we = 1'b0;
      case (mode)
         1: m_ready = (k % 4 == 0) || (k % 4 == 3);
         2: begin
            m_ready  = 1'b1;
            cap_en   = (k % 2 == 0);
            cap_we   = 1'b1;
            cap_addr = 18'h20000 + AW'(k);
            cap_data = 8'($urandom);
         end
         3: begin
            m_ready  = 1'($urandom);
            cap_en   = ($urandom_range(0, 2) == 0);
            cap_we   = 1'($urandom);
            cap_addr = 18'h20000 | AW'($urandom_range(0, 'hFFF));
            cap_data = 8'($urandom);
         end
         default: m_ready = 1'b1;
      endcase
      if (cap_en && cap_we) ref_wr[int'(cap_addr)] = cap_data;
   endtask

   task automatic run_burst(input logic [AW-1:0] base, input int cnt,
                            input int mode, input bit inject,
                            input bit timed);
      bit got;
      for (int i = 0; i < cnt; i++) begin
         logic [AW-1:0] a;
         a = base + AW'(i);
         exp_raddr.push_back(a);
         exp_data.push_back(ref_rd(a));
      end
      @(posedge clk); #1;
      rd_start = 1'b1;
      rd_base  = base;
      rd_count = (AW+1)'(cnt);
      drive_cycle(mode, 0);
      got = 1'b0;
      for (int k = 0; k < 2000 && !got; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            rd_start = inject && (k == 3);
            if (rd_start) begin
               rd_base  = 18'h30000;
               rd_count = 19'd3;
            end
            drive_cycle(mode, k);
         end
         @(negedge clk);
         if (timed && k == 1) chk("lat_busy", 32'(rd_busy), 32'd1);
         if (timed && k >= 1 && k <= RL + 2)
            chk("lat_valid", 32'(m_valid), 32'(k == RL + 2));
         if (mode == 2 && k == 2)
            chk("rd_after_cap", 32'(ram_en && !ram_we), 32'd1);
         if (rd_done) begin
            got = 1'b1;
            chk("done_busy", 32'(rd_busy), 32'd0);
            if (timed) chk("done_cycle", 32'(k), 32'(cnt + RL + 2));
         end
      end
      chk("done_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      rd_start = 1'b0;
      cap_en   = 1'b0;
      m_ready  = 1'b1;
      @(negedge clk);
      chk("done_pulse", 32'(rd_done), 32'd0);
      chk("sb_empty", 32'(exp_data.size() + exp_raddr.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, d0;
      bit reached;
      reset    = 1'b1;
      cap_en   = 1'b0;
      cap_we   = 1'b0;
      cap_addr = '0;
      cap_data = '0;
      rd_start = 1'b0;
      rd_base  = '0;
      rd_count = '0;
      m_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", 32'({ram_en, ram_we, rd_busy, rd_done, m_valid}), 32'd0);
      chk("rst_ram", 32'({ram_addr, ram_wdata}), 32'd0);
      chk("rst_mdata", 32'(m_data), 32'd0);
      chk("rst_capcnt", 32'(cap_wr_count), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_burst(18'h00010, 5, 0, 1'b0, 1'b1);
      run_burst(18'd262142, 4, 0, 1'b0, 1'b0);

      max_out = 0;
      run_burst(18'h00040, 8, 1, 1'b0, 1'b0);
      chk("max_outstanding_ok", 32'(max_out <= FD), 32'd1);

      run_burst(18'h00100, 16, 2, 1'b0, 1'b0);
      chk("cap_count", 32'(cap_wr_count), 32'(cap_strobes));

      @(posedge clk); #1;
      rd_start = 1'b1;
      rd_base  = 18'h00200;
      rd_count = '0;
      @(posedge clk); #1;
      rd_start = 1'b0;
      @(negedge clk);
      chk("zero_done", 32'({rd_done, rd_busy, ram_en}), 32'b100);
      @(negedge clk);
      chk("zero_done_once", 32'(rd_done), 32'd0);

      run_burst(18'h00500, 6, 0, 1'b1, 1'b0);

      for (int b = 0; b < 6; b++)
         run_burst(AW'($urandom_range(0, 'h1F000)),
                   $urandom_range(1, 40), 3, 1'b0, 1'b0);
      chk("cap_count_rand", 32'(cap_wr_count), 32'(cap_strobes));

      run_burst(18'h20000, 64, 0, 1'b0, 1'b0);

      h0 = hs_seen;
      for (int i = 0; i < 12; i++) begin
         logic [AW-1:0] a;
         a = 18'h00300 + AW'(i);
         exp_raddr.push_back(a);
         exp_data.push_back(ref_rd(a));
      end
      @(posedge clk); #1;
      rd_start = 1'b1;
      rd_base  = 18'h00300;
      rd_count = 19'd12;
      reached  = 1'b0;
      for (int k = 0; k < 40 && !reached; k++) begin
         @(posedge clk); #1;
         rd_start = 1'b0;
         reached  = (hs_seen - h0 >= 3);
      end
      chk("rst_reach3", 32'(reached), 32'd1);
      reset = 1'b1;
      exp_raddr.delete();
      exp_data.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ctrl",
          32'({ram_en, ram_we, rd_busy, rd_done, m_valid}), 32'd0);
      chk("mid_rst_ram", 32'({ram_addr, ram_wdata}), 32'd0);
      chk("mid_rst_mdata", 32'(m_data), 32'd0);
      chk("mid_rst_capcnt", 32'(cap_wr_count), 32'd0);
      d0 = done_cnt;
      repeat (12) @(negedge clk);
      chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("mid_rst_quiet", 32'({rd_busy, m_valid}), 32'd0);

      run_burst(18'h00400, 6, 0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
